// File: rtl/window_scanner.sv
// window_scanner: walks a KxK window over an IMG x IMG byte buffer in raster
// order, presenting one window at a time on a valid/ready handshake.
// Optional feature: define WINDOW_SUM_EN to add the registered 12-bit
// window_sum output (sum of the K*K window bytes).
//
// state | meaning
// IDLE  | waiting for start; scan position is reset to (0,0) on start
// LOAD  | capture window at (row,col) and raise out_valid
// SCAN  | hold window until accepted, then advance position
// DONE  | last window accepted; emit the one-cycle done pulse
module window_scanner #(
    parameter int IMG    = 13,
    parameter int K      = 3,
    parameter int STRIDE = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  in [0:IMG-1][0:IMG-1],
    output logic [7:0]  window [0:K*K-1],
    output logic [3:0]  win_row,
    output logic [3:0]  win_col,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        done
`ifdef WINDOW_SUM_EN
    ,
    output logic [11:0] window_sum
`endif
);
    localparam int N  = (IMG - K) / STRIDE + 1;
    localparam int IW = (IMG > 1) ? $clog2(IMG) : 1;
    localparam logic [3:0] STEP = 4'(STRIDE);
    localparam logic [3:0] LAST = 4'((N - 1) * STRIDE);

    typedef enum logic [1:0] {IDLE, LOAD, SCAN, DONE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  row_q, row_d;
    logic [3:0]  col_q, col_d;
    logic [3:0]  win_row_q, win_row_d;
    logic [3:0]  win_col_q, win_col_d;
    logic [7:0]  window_q [0:K*K-1];
    logic [7:0]  window_d [0:K*K-1];
    logic        valid_q, valid_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
`ifdef WINDOW_SUM_EN
    logic [11:0] sum_q, sum_d;
`endif

    // Next-state and registered-output computation for the scan sequencer.
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        win_row_d = win_row_q;
        win_col_d = win_col_q;
        window_d  = window_q;
        valid_d   = valid_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
`ifdef WINDOW_SUM_EN
        sum_d     = sum_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    row_d   = 4'd0;
                    col_d   = 4'd0;
                    busy_d  = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                for (int r = 0; r < K; r++) begin
                    for (int c = 0; c < K; c++) begin
                        window_d[r*K+c] = in[IW'(row_q + 4'(r))][IW'(col_q + 4'(c))];
                    end
                end
`ifdef WINDOW_SUM_EN
                sum_d = 12'd0;
                for (int r = 0; r < K; r++) begin
                    for (int c = 0; c < K; c++) begin
                        sum_d = sum_d + 12'(in[IW'(row_q + 4'(r))][IW'(col_q + 4'(c))]);
                    end
                end
`endif
                win_row_d = row_q;
                win_col_d = col_q;
                valid_d   = 1'b1;
                busy_d    = 1'b1;
                state_d   = SCAN;
            end
            SCAN: begin
                if (valid_q && out_ready) begin
                    valid_d = 1'b0;
                    if (row_q == LAST && col_q == LAST) begin
                        busy_d  = 1'b0;
                        state_d = DONE;
                    end else begin
                        if (col_q == LAST) begin
                            col_d = 4'd0;
                            row_d = row_q + STEP;
                        end else begin
                            col_d = col_q + STEP;
                        end
                        state_d = LOAD;
                    end
                end
            end
            DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            row_q     <= 4'd0;
            col_q     <= 4'd0;
            win_row_q <= 4'd0;
            win_col_q <= 4'd0;
            window_q  <= '{default: 8'h00};
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef WINDOW_SUM_EN
            sum_q     <= 12'd0;
`endif
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            win_row_q <= win_row_d;
            win_col_q <= win_col_d;
            window_q  <= window_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef WINDOW_SUM_EN
            sum_q     <= sum_d;
`endif
        end
    end

    assign window    = window_q;
    assign win_row   = win_row_q;
    assign win_col   = win_col_q;
    assign out_valid = valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
`ifdef WINDOW_SUM_EN
    assign window_sum = sum_q;
`endif

endmodule

// File: tb/tb_window_scanner.sv
// Testbench for window_scanner: default 13x13/K3/S1 instance plus a
// 13x13/K5/S4 instance, checked against a raster-order reference model.
`timescale 1ns/1ps
module tb_window_scanner;
    localparam int IMG = 13;
    localparam int K = 3, S = 1, N = (IMG - K) / S + 1, NW = N * N;
    localparam int K2 = 5, S2 = 4, N2 = (IMG - K2) / S2 + 1, NW2 = N2 * N2;

    logic clock = 1'b0;
    logic reset, start, out_ready, start2, out_ready2;
    logic [7:0] img [0:IMG-1][0:IMG-1];
    logic [7:0] window [0:K*K-1];
    logic [3:0] win_row, win_col;
    logic out_valid, busy, done;
    logic [7:0] window2 [0:K2*K2-1];
    logic [3:0] win_row2, win_col2;
    logic out_valid2, busy2, done2;
`ifdef WINDOW_SUM_EN
    logic [11:0] window_sum, window_sum2;
`endif
    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    window_scanner #(.IMG(IMG), .K(K), .STRIDE(S)) dut (
        .clock(clock), .reset(reset), .start(start), .in(img),
        .window(window), .win_row(win_row), .win_col(win_col),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done)
`ifdef WINDOW_SUM_EN
        , .window_sum(window_sum)
`endif
    );

    window_scanner #(.IMG(IMG), .K(K2), .STRIDE(S2)) dut2 (
        .clock(clock), .reset(reset), .start(start2), .in(img),
        .window(window2), .win_row(win_row2), .win_col(win_col2),
        .out_valid(out_valid2), .out_ready(out_ready2), .busy(busy2), .done(done2)
`ifdef WINDOW_SUM_EN
        , .window_sum(window_sum2)
`endif
    );

    // Element e of window number idx in raster order.
    function automatic logic [7:0] exp_pix(int idx, int n, int s, int k, int e);
        int er, ec;
        er = (idx / n) * s + e / k;
        ec = (idx % n) * s + e % k;
        return img[er][ec];
    endfunction

    task automatic fill_pattern;
        for (int r = 0; r < IMG; r++)
            for (int c = 0; c < IMG; c++) img[r][c] = 8'((13 * r + c) % 256);
    endtask

    task automatic fill_random;
        for (int r = 0; r < IMG; r++)
            for (int c = 0; c < IMG; c++) img[r][c] = 8'($urandom_range(0, 255));
    endtask

    task automatic fill_const;
        for (int r = 0; r < IMG; r++)
            for (int c = 0; c < IMG; c++) img[r][c] = 8'd255;
    endtask

    // Full scan on dut; mode 0: ready=1, 1: toggling ready, 2: random ready + stray starts.
    task automatic scan_dut1(input string tag, input int mode, input bit hold_start, input int stop_after);
        int idx = 0, first_v = -1, done_at = -1, dones = 0, es;
        bit stalled = 1'b0, bad;
        logic [7:0] held [0:K*K-1];
        logic [3:0] hr = 4'd0, hc = 4'd0;
        start = 1'b1;
        for (int cyc = 1; cyc <= 8 * NW + 50 && done_at < 0; cyc++) begin
            @(negedge clock);
            if (!hold_start)
                start = (mode == 2 && idx > 0 && idx < NW - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = cyc[0];
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (done) begin
                dones++;
                done_at = cyc;
            end
            if (out_valid) begin
                if (first_v < 0) first_v = cyc;
                if (stalled) begin
                    n_checks++;
                    bad = (win_row !== hr) || (win_col !== hc);
                    for (int e = 0; e < K * K; e++) if (window[e] !== held[e]) bad = 1'b1;
                    if (bad) begin
                        n_errors++;
                        $display("FAIL %s stall_hold idx=%0d: got (%0d,%0d) w0=%0d, want (%0d,%0d) w0=%0d",
                                 tag, idx, win_row, win_col, window[0], hr, hc, held[0]);
                    end
                end
                n_checks++;
                bad = (idx >= NW);
                if (!bad) begin
                    if (win_row !== 4'((idx / N) * S) || win_col !== 4'((idx % N) * S)) bad = 1'b1;
                    es = 0;
                    for (int e = 0; e < K * K; e++) begin
                        if (window[e] !== exp_pix(idx, N, S, K, e)) bad = 1'b1;
                        es += int'(exp_pix(idx, N, S, K, e));
                    end
`ifdef WINDOW_SUM_EN
                    if (window_sum !== 12'(es)) bad = 1'b1;
`endif
                end
                if (bad) begin
                    n_errors++;
                    $display("FAIL %s window idx=%0d: got (%0d,%0d) w0=%0d w%0d=%0d, want (%0d,%0d) w0=%0d w%0d=%0d",
                             tag, idx, win_row, win_col, window[0], K*K-1, window[K*K-1],
                             (idx / N) * S, (idx % N) * S,
                             (idx < NW) ? exp_pix(idx, N, S, K, 0) : 8'd0, K*K-1,
                             (idx < NW) ? exp_pix(idx, N, S, K, K*K-1) : 8'd0);
                end
                held = window;
                hr = win_row;
                hc = win_col;
                stalled = !out_ready;
                if (out_ready) begin
                    idx++;
                    if (stop_after > 0 && idx == stop_after) begin
                        start = 1'b0;
                        @(negedge clock);
                        return;
                    end
                end
            end else begin
                stalled = 1'b0;
            end
        end
        start = hold_start;
        n_checks++;
        if (idx !== NW) begin
            n_errors++;
            $display("FAIL %s window_count: got %0d, want %0d", tag, idx, NW);
        end
        n_checks++;
        if (dones !== 1) begin
            n_errors++;
            $display("FAIL %s done_count: got %0d, want 1", tag, dones);
        end
        if (mode == 0) begin
            n_checks++;
            if (done_at - first_v !== 2 * NW) begin
                n_errors++;
                $display("FAIL %s done_latency: got %0d, want %0d", tag, done_at - first_v, 2 * NW);
            end
        end
        @(negedge clock);
        n_checks++;
        if (done !== 1'b0 || out_valid !== 1'b0 || busy !== hold_start) begin
            n_errors++;
            $display("FAIL %s after_done: got done=%0d valid=%0d busy=%0d, want 0 0 %0d",
                     tag, done, out_valid, busy, hold_start);
        end
        @(negedge clock);
        n_checks++;
        if (out_valid !== hold_start || (hold_start && (win_row !== 4'd0 || win_col !== 4'd0))) begin
            n_errors++;
            $display("FAIL %s restart: got valid=%0d (%0d,%0d), want valid=%0d at (0,0)",
                     tag, out_valid, win_row, win_col, hold_start);
        end
    endtask

    task automatic test_reset;
        bit bad;
        reset = 1'b1; start = 1'b0; out_ready = 1'b0; start2 = 1'b0; out_ready2 = 1'b0;
        fill_pattern;
        repeat (2) @(negedge clock);
        n_checks++;
        bad = (out_valid !== 0) || (busy !== 0) || (done !== 0) || (win_row !== 0) || (win_col !== 0);
        for (int e = 0; e < K * K; e++) if (window[e] !== 8'd0) bad = 1'b1;
        if (bad) begin
            n_errors++;
            $display("FAIL reset_state: got valid=%0d busy=%0d done=%0d (%0d,%0d) w0=%0d, want all 0",
                     out_valid, busy, done, win_row, win_col, window[0]);
        end
        n_checks++;
        if (out_valid2 !== 0 || busy2 !== 0 || done2 !== 0) begin
            n_errors++;
            $display("FAIL reset_state2: got valid=%0d busy=%0d done=%0d, want 0", out_valid2, busy2, done2);
        end
        reset = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(negedge clock);
        n_checks++;
        if (out_valid !== 0 || busy !== 0) begin
            n_errors++;
            $display("FAIL idle_ready: got valid=%0d busy=%0d, want 0 0", out_valid, busy);
        end
    endtask

    task automatic test_raster;
        fill_pattern;
        scan_dut1("raster", 0, 1'b0, 0);
    endtask

    task automatic test_toggle_ready;
        fill_pattern;
        scan_dut1("toggle", 1, 1'b0, 0);
    endtask

    task automatic test_start_held;
        fill_pattern;
        scan_dut1("start_held", 0, 1'b1, 0);
        start = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_mid_reset;
        bit bad;
        fill_pattern;
        scan_dut1("pre_reset", 2, 1'b0, 50);
        reset = 1'b1;
        #1;
        n_checks++;
        bad = (out_valid !== 0) || (busy !== 0) || (done !== 0) || (win_row !== 0) || (win_col !== 0);
        for (int e = 0; e < K * K; e++) if (window[e] !== 8'd0) bad = 1'b1;
        if (bad) begin
            n_errors++;
            $display("FAIL mid_reset: got valid=%0d busy=%0d done=%0d (%0d,%0d), want all 0",
                     out_valid, busy, done, win_row, win_col);
        end
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        n_checks++;
        if (done !== 0 || busy !== 0 || out_valid !== 0) begin
            n_errors++;
            $display("FAIL post_reset_idle: got done=%0d busy=%0d valid=%0d, want 0", done, busy, out_valid);
        end
        scan_dut1("restart", 0, 1'b0, 0);
    endtask

    task automatic test_random_image;
        fill_random;
        scan_dut1("random", 2, 1'b0, 0);
    endtask

    task automatic test_saturated;
        fill_const;
        scan_dut1("saturated", 2, 1'b0, 0);
    endtask

    task automatic test_stride;
        int idx = 0, dones = 0, es;
        bit bad;
        fill_random;
        start2 = 1'b1;
        for (int cyc = 0; cyc < 400 && dones == 0; cyc++) begin
            @(negedge clock);
            start2 = 1'b0;
            out_ready2 = 1'($urandom_range(0, 1));
            if (done2) dones++;
            if (out_valid2 && out_ready2) begin
                n_checks++;
                bad = (idx >= NW2);
                if (!bad) begin
                    if (win_row2 !== 4'((idx / N2) * S2) || win_col2 !== 4'((idx % N2) * S2)) bad = 1'b1;
                    es = 0;
                    for (int e = 0; e < K2 * K2; e++) begin
                        if (window2[e] !== exp_pix(idx, N2, S2, K2, e)) bad = 1'b1;
                        es += int'(exp_pix(idx, N2, S2, K2, e));
                    end
`ifdef WINDOW_SUM_EN
                    if (window_sum2 !== 12'(es)) bad = 1'b1;
`endif
                end
                if (bad) begin
                    n_errors++;
                    $display("FAIL stride window idx=%0d: got (%0d,%0d) w0=%0d, want (%0d,%0d)",
                             idx, win_row2, win_col2, window2[0], (idx / N2) * S2, (idx % N2) * S2);
                end
                idx++;
            end
        end
        out_ready2 = 1'b0;
        n_checks++;
        if (idx !== NW2) begin
            n_errors++;
            $display("FAIL stride window_count: got %0d, want %0d", idx, NW2);
        end
        n_checks++;
        if (dones !== 1) begin
            n_errors++;
            $display("FAIL stride done_count: got %0d, want 1", dones);
        end
        @(negedge clock);
    endtask

    initial begin
        test_reset;
        test_raster;
        test_toggle_ready;
        test_start_held;
        test_mid_reset;
        test_random_image;
        test_saturated;
        test_stride;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
